keypad_scanner: RTL

- Drives a 4x4 matrix keypad and produces the `key_in`/`key_valid` stream that the password lock FSM consumes.
- Scans columns one at a time and samples rows, then rejects multi-key frames and debounces across whole scan frames.
- Emits exactly one `key_valid` strobe per accepted press.
- Sits between the keypad pins and the lock FSM. It is the transmitter for that FSM's key interface.

---
 rtl/keypad_scanner.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one column at a time, collects the
//   row samples of a whole scan frame, rejects frames with more than one key
//   down (ghosting), debounces across frames and emits one key_valid strobe
//   per accepted press on the key_in/key_valid stream.
//
// Parameters
//   SCAN_DIV      cycles each column is driven (4..256)
//   DEBOUNCE_CNT  identical frames needed to accept a press or release (1..15)
//   REPEAT_FRAMES auto-repeat period in frames (2..255), auto-repeat only
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-low reset (0 = reset)
//   row_in     keypad rows, active-low, asynchronous
//   col_out    column drive, active-low one-hot
//   key_in     code {row,col} of the last accepted key
//   key_valid  one-cycle strobe, key_in holds a new key
//   key_held   high while an accepted key remains pressed
//
// Build option
//   KEYPAD_AUTOREPEAT_EN  when defined, a held key re-strobes every
//                         REPEAT_FRAMES frames; when undefined no repeat
//                         logic exists and each press strobes exactly once.

module keypad_scanner #(
   parameter int SCAN_DIV      = 16,
   parameter int DEBOUNCE_CNT  = 3,
   parameter int REPEAT_FRAMES = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] key_in,
   output logic       key_valid,
   output logic       key_held
);

   generate
      if (SCAN_DIV < 4 || SCAN_DIV > 256 || DEBOUNCE_CNT < 1 || DEBOUNCE_CNT > 15 ||
          REPEAT_FRAMES < 2 || REPEAT_FRAMES > 255) begin : g_bad_params
         $error("keypad_scanner: parameter out of legal range");
      end
   endgenerate

   localparam logic [7:0] SLOT_LAST = 8'(SCAN_DIV - 1);
   localparam logic [3:0] DB_CNT    = 4'(DEBOUNCE_CNT);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   logic [3:0] row_meta;
   logic [3:0] row_sync;
   logic [7:0] slot_cnt;
   logic [1:0] col_idx;
   logic       slot_end;
   logic       frame_tick;

   // Frame accumulator: hit_cnt saturates at 2 meaning "two or more keys".
   logic [1:0] hit_cnt;
   logic [3:0] hit_code;
   logic [2:0] slot_hits;
   logic [1:0] slot_row;
   logic [2:0] merged_sum;
   logic [1:0] merged_cnt;
   logic [3:0] merged_code;
   logic       frame_single;
   logic [3:0] frame_key;

   state_t     state;
   state_t     state_n;
   logic [3:0] cnt;
   logic [3:0] cnt_n;
   logic [3:0] cnt_inc;
   logic [3:0] cand;
   logic [3:0] cand_n;
   logic       accept;
   logic       rep_fire;

   assign slot_end   = (slot_cnt == SLOT_LAST);
   assign frame_tick = slot_end && (col_idx == 2'd3);

   // Rows are sampled on the last cycle of a slot. With SCAN_DIV >= 4 the
   // synchronized value then reflects row_in from at least one cycle after
   // the column changed, so the previous column never leaks into a sample.
   always_ff @(posedge clk) begin
      if (!reset) begin
         row_meta <= 4'hF;
         row_sync <= 4'hF;
         slot_cnt <= 8'd0;
         col_idx  <= 2'd0;
         col_out  <= 4'b1110;
         hit_cnt  <= 2'd0;
         hit_code <= 4'd0;
      end else begin
         row_meta <= row_in;
         row_sync <= row_meta;
         if (slot_end) begin
            slot_cnt <= 8'd0;
            col_idx  <= col_idx + 2'd1;
            col_out  <= {col_out[2:0], col_out[3]};
            if (frame_tick) begin
               hit_cnt  <= 2'd0;
               hit_code <= 4'd0;
            end else begin
               hit_cnt  <= merged_cnt;
               hit_code <= merged_code;
            end
         end else begin
            slot_cnt <= slot_cnt + 8'd1;
         end
      end
   end

   always_comb begin
      slot_hits = 3'd0;
      slot_row  = 2'd0;
      for (int r = 3; r >= 0; r--) begin
         if (!row_sync[r]) begin
            slot_hits = slot_hits + 3'd1;
            slot_row  = r[1:0];
         end
      end
   end

   // The frame result includes the column-3 sample taken on the tick itself.
   always_comb begin
      merged_sum  = {1'b0, hit_cnt} + slot_hits;
      merged_cnt  = (merged_sum >= 3'd2) ? 2'd2 : merged_sum[1:0];
      merged_code = ((hit_cnt == 2'd0) && (slot_hits == 3'd1)) ? {slot_row, col_idx} : hit_code;
   end

   assign frame_single = (merged_cnt == 2'd1);
   assign frame_key    = merged_code;
   assign cnt_inc      = (cnt >= DB_CNT) ? DB_CNT : cnt + 4'd1;

   // State register together with the debounce count, candidate and outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         cand      <= 4'd0;
         key_in    <= 4'd0;
         key_valid <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         cand      <= cand_n;
         key_valid <= accept | rep_fire;
         if (accept) begin
            key_in <= cand_n;
         end
      end
   end

   // Next-state logic; nothing moves except on a frame-end tick.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      cand_n  = cand;
      accept  = 1'b0;
      if (frame_tick) begin
         case (state)
            IDLE: begin
               if (frame_single) begin
                  cand_n = frame_key;
                  cnt_n  = 4'd1;
                  if (DB_CNT == 4'd1) begin
                     state_n = PRESSED;
                     cnt_n   = 4'd0;
                     accept  = 1'b1;
                  end else begin
                     state_n = DEBOUNCE;
                  end
               end
            end
            DEBOUNCE: begin
               if (!frame_single) begin
                  state_n = IDLE;
                  cnt_n   = 4'd0;
               end else if (frame_key == cand) begin
                  if (cnt_inc >= DB_CNT) begin
                     state_n = PRESSED;
                     cnt_n   = 4'd0;
                     accept  = 1'b1;
                  end else begin
                     cnt_n = cnt_inc;
                  end
               end else begin
                  cand_n = frame_key;
                  cnt_n  = 4'd1;
                  if (DB_CNT == 4'd1) begin
                     state_n = PRESSED;
                     cnt_n   = 4'd0;
                     accept  = 1'b1;
                  end
               end
            end
            PRESSED: begin
               // A different single key while held is ignored: no rollover.
               if (!frame_single) begin
                  if (DB_CNT == 4'd1) begin
                     state_n = IDLE;
                     cnt_n   = 4'd0;
                  end else begin
                     state_n = RELEASE;
                     cnt_n   = 4'd1;
                  end
               end
            end
            RELEASE: begin
               if (frame_single) begin
                  state_n = PRESSED;
                  cnt_n   = 4'd0;
               end else if (cnt_inc >= DB_CNT) begin
                  state_n = IDLE;
                  cnt_n   = 4'd0;
               end else begin
                  cnt_n = cnt_inc;
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = 4'd0;
            end
         endcase
      end
   end

   always_comb begin
      key_held = (state == PRESSED) || (state == RELEASE);
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam logic [7:0] REP_LAST = 8'(REPEAT_FRAMES - 1);

   logic [7:0] rep_cnt;

   assign rep_fire = frame_tick && (state == PRESSED) && frame_single && (rep_cnt == REP_LAST);

   // Held outside PRESSED at zero, so entering PRESSED always starts a full period.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rep_cnt <= 8'd0;
      end else if (state != PRESSED) begin
         rep_cnt <= 8'd0;
      end else if (frame_tick && frame_single) begin
         rep_cnt <= rep_fire ? 8'd0 : rep_cnt + 8'd1;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

endmodule
